// File: rtl/mips_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mips_pkg
// Description : Shared widths and MEM/WB payload type for the MIPS pipeline.
// Revision    : 1.0 - initial release
// ============================================================================
package mips_pkg;

    localparam int DATA_WIDTH = 32;
    localparam int REG_ADDR_W = 5;
    localparam int ADDR_LSB   = 2;

    typedef struct packed {
        logic                  regWrite;
        logic                  memToReg;
        logic [DATA_WIDTH-1:0] read_data;
        logic [DATA_WIDTH-1:0] alu_result;
        logic [REG_ADDR_W-1:0] write_register;
    } mem_wb_t;

endpackage : mips_pkg
`default_nettype wire

// File: rtl/data_memory.sv
`default_nettype none
// ============================================================================
// Module      : data_memory
// Description : Word-indexed RAM, synchronous write, asynchronous read.
// Revision    : 1.0 - initial release
// ============================================================================
module data_memory
    import mips_pkg::*;
#(
    parameter int DATA_WIDTH_P = DATA_WIDTH,
    parameter int MEM_DEPTH    = 256,
    parameter int IDX_W        = $clog2(MEM_DEPTH)
) (
    input  logic                    clk,
    input  logic                    we,
    input  logic [IDX_W-1:0]        idx,
    input  logic [DATA_WIDTH_P-1:0] wdata,
    output logic [DATA_WIDTH_P-1:0] rdata
);

    logic [DATA_WIDTH_P-1:0] r_mem [MEM_DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[idx] <= wdata;
        end
    end

    // Same-index load and store see the old word: the write lands after the edge.
    assign rdata = r_mem[idx];

endmodule : data_memory
`default_nettype wire

// File: rtl/mem_access_stage.sv
`default_nettype none
// ============================================================================
// Module      : mem_access_stage
// Description : MEM stage - branch resolve, data memory access, MEM/WB register.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_access_stage
    import mips_pkg::*;
#(
    parameter int MEM_DEPTH = 256
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  ctrl_regWrite_ex_mem,
    input  logic                  ctrl_memToReg_ex_mem,
    input  logic                  ctrl_branch_ex_mem,
    input  logic                  ctrl_memRead_ex_mem,
    input  logic                  ctrl_memWrite_ex_mem,
    input  logic                  zero_ex_mem,
    input  logic [DATA_WIDTH-1:0] branch_or_not_address_ex_mem,
    input  logic [DATA_WIDTH-1:0] alu_result_ex_mem,
    input  logic [DATA_WIDTH-1:0] read_data_2_ex_mem,
    input  logic [REG_ADDR_W-1:0] write_register_ex_mem,
    output logic                  pc_src,
    output logic [DATA_WIDTH-1:0] branch_target,
    output logic                  ctrl_regWrite_mem_wb,
    output logic                  ctrl_memToReg_mem_wb,
    output logic [DATA_WIDTH-1:0] read_data_mem_wb,
    output logic [DATA_WIDTH-1:0] alu_result_mem_wb,
    output logic [REG_ADDR_W-1:0] write_register_mem_wb,
    output logic                  misaligned_fault
);

    localparam int c_IDX_W = $clog2(MEM_DEPTH);

    logic                  w_mis;
    logic                  w_we;
    logic [c_IDX_W-1:0]    w_idx;
    logic [DATA_WIDTH-1:0] w_rdata;
    mem_wb_t               r_mem_wb;
    logic                  r_fault;

    assign pc_src        = ctrl_branch_ex_mem & zero_ex_mem;
    assign branch_target = branch_or_not_address_ex_mem;

    assign w_idx = alu_result_ex_mem[ADDR_LSB +: c_IDX_W];
    assign w_mis = (ctrl_memRead_ex_mem | ctrl_memWrite_ex_mem)
                 & (alu_result_ex_mem[1:0] != 2'b00);
    // Gating with reset drops a store on the edge where reset is being asserted.
    assign w_we  = ctrl_memWrite_ex_mem & ~w_mis & reset;

    data_memory #(
        .DATA_WIDTH_P (DATA_WIDTH),
        .MEM_DEPTH    (MEM_DEPTH),
        .IDX_W        (c_IDX_W)
    ) u_data_memory (
        .clk   (clk),
        .we    (w_we),
        .idx   (w_idx),
        .wdata (read_data_2_ex_mem),
        .rdata (w_rdata)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_mem_wb <= '0;
            r_fault  <= 1'b0;
        end else begin
            r_mem_wb.regWrite       <= ctrl_regWrite_ex_mem & ~w_mis;
            r_mem_wb.memToReg       <= ctrl_memToReg_ex_mem;
            r_mem_wb.read_data      <= (ctrl_memRead_ex_mem & ~w_mis) ? w_rdata : '0;
            r_mem_wb.alu_result     <= alu_result_ex_mem;
            r_mem_wb.write_register <= write_register_ex_mem;
            if (w_mis) begin
                r_fault <= 1'b1;
            end
        end
    end

    assign ctrl_regWrite_mem_wb  = r_mem_wb.regWrite;
    assign ctrl_memToReg_mem_wb  = r_mem_wb.memToReg;
    assign read_data_mem_wb      = r_mem_wb.read_data;
    assign alu_result_mem_wb     = r_mem_wb.alu_result;
    assign write_register_mem_wb = r_mem_wb.write_register;
    assign misaligned_fault      = r_fault;

endmodule : mem_access_stage
`default_nettype wire

// File: tb/tb_mem_access_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_access_stage
// Description : Directed self-checking bench for the MEM pipeline stage.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_access_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        regWrite, memToReg, branch, memRead, memWrite, zero;
    logic [31:0] target, alu, wdata;
    logic [4:0]  wreg;
    logic        pc_src;
    logic [31:0] branch_target;
    logic        rw_wb, m2r_wb;
    logic [31:0] rd_wb, alu_wb;
    logic [4:0]  wreg_wb;
    logic        fault;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    mem_access_stage #(.MEM_DEPTH(256)) dut (
        .clk                          (clk),
        .reset                        (reset),
        .ctrl_regWrite_ex_mem         (regWrite),
        .ctrl_memToReg_ex_mem         (memToReg),
        .ctrl_branch_ex_mem           (branch),
        .ctrl_memRead_ex_mem          (memRead),
        .ctrl_memWrite_ex_mem         (memWrite),
        .zero_ex_mem                  (zero),
        .branch_or_not_address_ex_mem (target),
        .alu_result_ex_mem            (alu),
        .read_data_2_ex_mem           (wdata),
        .write_register_ex_mem        (wreg),
        .pc_src                       (pc_src),
        .branch_target                (branch_target),
        .ctrl_regWrite_mem_wb         (rw_wb),
        .ctrl_memToReg_mem_wb         (m2r_wb),
        .read_data_mem_wb             (rd_wb),
        .alu_result_mem_wb            (alu_wb),
        .write_register_mem_wb        (wreg_wb),
        .misaligned_fault             (fault)
    );

    task automatic drive(input logic rw, input logic m2r, input logic rd, input logic wr,
                         input logic [31:0] a, input logic [31:0] d, input logic [4:0] r);
        regWrite = rw; memToReg = m2r; memRead = rd; memWrite = wr;
        alu = a; wdata = d; wreg = r;
        branch = 1'b0; zero = 1'b0; target = 32'h0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        total++; if (rw_wb !== 1'b0) $display("FAIL reset_regWrite got %0b want 0", rw_wb); else passed++;
        total++; if (m2r_wb !== 1'b0) $display("FAIL reset_memToReg got %0b want 0", m2r_wb); else passed++;
        total++; if (rd_wb !== 32'h0) $display("FAIL reset_read_data got %h want 0", rd_wb); else passed++;
        total++; if (alu_wb !== 32'h0) $display("FAIL reset_alu got %h want 0", alu_wb); else passed++;
        total++; if (wreg_wb !== 5'd0) $display("FAIL reset_wreg got %0d want 0", wreg_wb); else passed++;
        total++; if (fault !== 1'b0) $display("FAIL reset_fault got %0b want 0", fault); else passed++;
    endtask

    task automatic test_store_load();
        drive(1'b0, 1'b0, 1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 5'd0);
        step();
        drive(1'b1, 1'b1, 1'b1, 1'b0, 32'h10, 32'h0, 5'd5);
        step();
        total++; if (rd_wb !== 32'hDEADBEEF) $display("FAIL load_data got %h want deadbeef", rd_wb); else passed++;
        total++; if (wreg_wb !== 5'd5) $display("FAIL load_wreg got %0d want 5", wreg_wb); else passed++;
        total++; if (m2r_wb !== 1'b1) $display("FAIL load_memToReg got %0b want 1", m2r_wb); else passed++;
        total++; if (rw_wb !== 1'b1) $display("FAIL load_regWrite got %0b want 1", rw_wb); else passed++;
        total++; if (alu_wb !== 32'h10) $display("FAIL load_alu got %h want 10", alu_wb); else passed++;
        total++; if (fault !== 1'b0) $display("FAIL load_fault got %0b want 0", fault); else passed++;
    endtask

    task automatic test_branch();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
        branch = 1'b1; zero = 1'b1; target = 32'h40;
        #1;
        total++; if (pc_src !== 1'b1) $display("FAIL branch_taken got %0b want 1", pc_src); else passed++;
        total++; if (branch_target !== 32'h40) $display("FAIL branch_target got %h want 40", branch_target); else passed++;
        zero = 1'b0;
        #1;
        total++; if (pc_src !== 1'b0) $display("FAIL branch_zero0 got %0b want 0", pc_src); else passed++;
        branch = 1'b0; zero = 1'b1;
        #1;
        total++; if (pc_src !== 1'b0) $display("FAIL branch_nobranch got %0b want 0", pc_src); else passed++;
        step();
    endtask

    task automatic test_misaligned();
        drive(1'b1, 1'b0, 1'b0, 1'b1, 32'h12, 32'h12345678, 5'd3);
        step();
        total++; if (fault !== 1'b1) $display("FAIL mis_fault got %0b want 1", fault); else passed++;
        total++; if (rw_wb !== 1'b0) $display("FAIL mis_squash got %0b want 0", rw_wb); else passed++;
        total++; if (alu_wb !== 32'h12) $display("FAIL mis_alu got %h want 12", alu_wb); else passed++;
        total++; if (wreg_wb !== 5'd3) $display("FAIL mis_wreg got %0d want 3", wreg_wb); else passed++;
        drive(1'b1, 1'b1, 1'b1, 1'b0, 32'h11, 32'h0, 5'd4);
        step();
        total++; if (rd_wb !== 32'h0) $display("FAIL mis_load_data got %h want 0", rd_wb); else passed++;
        total++; if (rw_wb !== 1'b0) $display("FAIL mis_load_squash got %0b want 0", rw_wb); else passed++;
        drive(1'b1, 1'b1, 1'b1, 1'b0, 32'h10, 32'h0, 5'd6);
        step();
        total++; if (rd_wb !== 32'hDEADBEEF) $display("FAIL mis_store_suppressed got %h want deadbeef", rd_wb); else passed++;
        total++; if (rw_wb !== 1'b1) $display("FAIL mis_aligned_regWrite got %0b want 1", rw_wb); else passed++;
        total++; if (fault !== 1'b1) $display("FAIL mis_sticky got %0b want 1", fault); else passed++;
    endtask

    task automatic test_wrap();
        drive(1'b0, 1'b0, 1'b0, 1'b1, 32'h400, 32'h1, 5'd0);
        step();
        drive(1'b1, 1'b1, 1'b1, 1'b0, 32'h0, 32'h0, 5'd8);
        step();
        total++; if (rd_wb !== 32'h1) $display("FAIL wrap_data got %h want 1", rd_wb); else passed++;
    endtask

    task automatic test_read_before_write();
        drive(1'b0, 1'b0, 1'b0, 1'b1, 32'h20, 32'h3, 5'd0);
        step();
        drive(1'b1, 1'b1, 1'b1, 1'b1, 32'h20, 32'h5, 5'd9);
        step();
        total++; if (rd_wb !== 32'h3) $display("FAIL rbw_old got %h want 3", rd_wb); else passed++;
        drive(1'b1, 1'b1, 1'b1, 1'b0, 32'h20, 32'h0, 5'd9);
        step();
        total++; if (rd_wb !== 32'h5) $display("FAIL rbw_new got %h want 5", rd_wb); else passed++;
    endtask

    task automatic test_back_to_back();
        drive(1'b0, 1'b0, 1'b0, 1'b1, 32'h24, 32'hA5A5_0001, 5'd0);
        step();
        drive(1'b0, 1'b0, 1'b0, 1'b1, 32'h28, 32'hA5A5_0002, 5'd0);
        step();
        drive(1'b1, 1'b1, 1'b1, 1'b0, 32'h24, 32'h0, 5'd10);
        step();
        total++; if (rd_wb !== 32'hA5A5_0001) $display("FAIL b2b_first got %h want a5a50001", rd_wb); else passed++;
        drive(1'b1, 1'b0, 1'b1, 1'b0, 32'h28, 32'h0, 5'd11);
        step();
        total++; if (rd_wb !== 32'hA5A5_0002) $display("FAIL b2b_second got %h want a5a50002", rd_wb); else passed++;
        total++; if (wreg_wb !== 5'd11) $display("FAIL b2b_wreg got %0d want 11", wreg_wb); else passed++;
        drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h28, 32'h0, 5'd12);
        step();
        total++; if (rd_wb !== 32'h0) $display("FAIL noload_data got %h want 0", rd_wb); else passed++;
    endtask

    task automatic test_reset_mid();
        drive(1'b1, 1'b1, 1'b1, 1'b0, 32'h10, 32'h0, 5'd7);
        step();
        #2;
        reset = 1'b0;
        #1;
        total++; if (rd_wb !== 32'h0) $display("FAIL mid_reset_data got %h want 0", rd_wb); else passed++;
        total++; if (wreg_wb !== 5'd0) $display("FAIL mid_reset_wreg got %0d want 0", wreg_wb); else passed++;
        total++; if (rw_wb !== 1'b0) $display("FAIL mid_reset_regWrite got %0b want 0", rw_wb); else passed++;
        total++; if (fault !== 1'b0) $display("FAIL mid_reset_fault got %0b want 0", fault); else passed++;
        total++; if (alu_wb !== 32'h0) $display("FAIL mid_reset_alu got %h want 0", alu_wb); else passed++;
        @(negedge clk);
        drive(1'b1, 1'b1, 1'b1, 1'b0, 32'h20, 32'h0, 5'd9);
        reset = 1'b1;
        #1;
        total++; if (wreg_wb !== 5'd0) $display("FAIL post_reset_early got %0d want 0", wreg_wb); else passed++;
        step();
        total++; if (rd_wb !== 32'h5) $display("FAIL post_reset_data got %h want 5", rd_wb); else passed++;
        total++; if (wreg_wb !== 5'd9) $display("FAIL post_reset_wreg got %0d want 9", wreg_wb); else passed++;
    endtask

    initial begin
        reset = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
        step();
        step();
        test_reset();
        @(negedge clk);
        reset = 1'b1;
        test_store_load();
        test_branch();
        test_misaligned();
        test_wrap();
        test_read_before_write();
        test_back_to_back();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule : tb_mem_access_stage
`default_nettype wire
